ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
EX/MEM pipeline register of the 5-stage 16-bit pipelined core. It captures execute-stage results and control each cycle and presents them to the data-memory stage, which consumes address, store data, read/write enables and halt. It handles stall hold and flush bubble insertion, and keeps a sticky halt that squashes younger memory operations. It also applies last-chance store-data forwarding from writeback at the latch point.

Parameters:
DW, 16, datapath width (address and data)
RW, 3, register index width

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold all registers (memory stage not ready / hazard unit)
flush  in  1  replace incoming instruction with bubble
ex_valid  in  1  execute stage holds a real instruction
ex_alu_result  in  DW  address / ALU result
ex_write_data  in  DW  store data from register file (pre-forward)
ex_rt  in  RW  source register index of store data
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_reg_write  in  1  instruction writes a register
ex_write_reg  in  RW  destination register
ex_mem_to_reg  in  1  writeback selects load data
ex_halt  in  1  HALT instruction
wb_reg_write  in  1  writeback stage writing a register this cycle
wb_write_reg  in  RW  writeback destination
wb_data  in  DW  writeback value
mem_valid  out  1  latched instruction is real
mem_alu_result  out  DW  to memory-stage address
mem_write_data  out  DW  to memory-stage store data
mem_read  out  1  gated load enable
mem_write  out  1  gated store enable
mem_reg_write  out  1  to MEM/WB
mem_write_reg  out  RW  to MEM/WB
mem_mem_to_reg  out  1  to MEM/WB
mem_halt  out  1  to memory-stage halt (dump trigger)
halt_seen  out  1  sticky: a halt has been latched

Behaviour:
- Reset (rst=0, asynchronous): every output and halt_seen = 0. Operation resumes on the first rising edge after rst returns to 1.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Priority per edge: flush > stall > load.
- flush=1: latch a bubble. mem_valid, mem_read, mem_write, mem_reg_write, mem_mem_to_reg and mem_halt = 0; data fields = 0. This holds even when stall=1.
- stall=1 and flush=0: all registers hold, including halt_seen.
- Load, with flush=0 and stall=0:
  - If halt_seen=1 or ex_valid=0, latch a bubble.
  - Otherwise latch all ex_* fields, and every control output is ANDed with valid.
- Store-data forwarding at load time: when ex_mem_write=1, wb_reg_write=1 and wb_write_reg==ex_rt, mem_write_data := wb_data; otherwise it takes ex_write_data. Register index 0 is not special.
- halt_seen: set on the edge that latches a valid ex_halt=1 and stays 1 until reset.
  - mem_halt follows the latched instruction; it is not sticky, so it stays asserted only while stalled.
  - Every instruction after the halt becomes a bubble, so no memory access occurs after halt.
- mem_read and mem_write are never both 1. If both ex_mem_read and ex_mem_write are 1, latch mem_write=1 and mem_read=0 (illegal encoding, store wins).
- No arithmetic in the datapath; all fields pass straight through.

Optional Feature:
Macro: EX_MEM_PERF_EN.
- Defined: adds outputs perf_mem_ops (16b) and perf_stall_cycles (16b).
  - perf_mem_ops increments on each edge latching a valid load or store.
  - perf_stall_cycles increments on each edge with stall=1 and mem_valid=1.
  - Both saturate at 16'hFFFF and reset to 0 on rst=0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg: DW/RW constants, a packed ex_mem control struct (valid, mem_read, mem_write, reg_write, write_reg, mem_to_reg, halt), a BUBBLE constant, and SAT16 max.
- Optional sub-module sat_counter (width parameter, inc, async active-low reset), instantiated twice under EX_MEM_PERF_EN.
- Core register and forward logic stay flat.

Test Plan:
- Reset mid-operation: drive valid store (alu=16'h0040, data=16'h1234), pull rst=0 between edges -> all outputs 0 immediately, no mem_write on next edge.
- Pipe through: valid load alu=16'h0010, write_reg=3 -> next cycle mem_read=1, mem_alu_result=16'h0010, mem_write_reg=3, mem_mem_to_reg=1.
- Stall then flush+stall: latch store (16'h0022, 16'hBEEF), stall 3 cycles -> outputs unchanged. Then flush=1 with stall=1 -> bubble, mem_write=0.
- Forwarding: store with ex_rt=5, ex_write_data=16'h0000, wb_reg_write=1, wb_write_reg=5, wb_data=16'hA5A5 -> mem_write_data=16'hA5A5. With wb_write_reg=4 -> 16'h0000.
- Halt: valid halt, then valid store to 16'h0100 -> mem_halt=1 for one cycle, halt_seen=1 stays 1, following mem_write=0 and mem_valid=0.
- Both read and write asserted: ex_mem_read=1, ex_mem_write=1 -> mem_write=1, mem_read=0. With EX_MEM_PERF_EN, perf_mem_ops increments by 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and types for the EX/MEM pipeline register.
// Referenced by ex_mem_pipe, its bus interface and the optional counters (EX_MEM_PERF_EN).
package pipe_pkg;

    localparam int DW = 16;
    localparam int RW = 3;

    localparam logic [15:0] SAT16 = 16'hFFFF;

    typedef struct packed {
        logic          valid;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic [RW-1:0] write_reg;
        logic          mem_to_reg;
        logic          halt;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Store data is replaced by the writeback value when writeback targets the store source.
    function automatic logic [DW-1:0] fwd_store_data(
        input logic          is_store,
        input logic [RW-1:0] rt,
        input logic [DW-1:0] reg_data,
        input logic          wb_reg_write,
        input logic [RW-1:0] wb_write_reg,
        input logic [DW-1:0] wb_data
    );
        logic [DW-1:0] sel;
        if (is_store && wb_reg_write && (wb_write_reg == rt)) begin
            sel = wb_data;
        end else begin
            sel = reg_data;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// EX/MEM bus: execute-side fields, writeback forward source, and memory-stage outputs.
interface ex_mem_pipe_if;
    import pipe_pkg::*;

    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] ex_alu_result;
    logic [DW-1:0] ex_write_data;
    logic [RW-1:0] ex_rt;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_reg_write;
    logic [RW-1:0] ex_write_reg;
    logic          ex_mem_to_reg;
    logic          ex_halt;
    logic          wb_reg_write;
    logic [RW-1:0] wb_write_reg;
    logic [DW-1:0] wb_data;
    logic          mem_valid;
    logic [DW-1:0] mem_alu_result;
    logic [DW-1:0] mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic          mem_reg_write;
    logic [RW-1:0] mem_write_reg;
    logic          mem_mem_to_reg;
    logic          mem_halt;
    logic          halt_seen;

    modport slave (
        input  stall, flush, ex_valid, ex_alu_result, ex_write_data, ex_rt,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_write_reg,
               ex_mem_to_reg, ex_halt, wb_reg_write, wb_write_reg, wb_data,
        output mem_valid, mem_alu_result, mem_write_data, mem_read, mem_write,
               mem_reg_write, mem_write_reg, mem_mem_to_reg, mem_halt, halt_seen
    );

    modport master (
        output stall, flush, ex_valid, ex_alu_result, ex_write_data, ex_rt,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_write_reg,
               ex_mem_to_reg, ex_halt, wb_reg_write, wb_write_reg, wb_data,
        input  mem_valid, mem_alu_result, mem_write_data, mem_read, mem_write,
               mem_reg_write, mem_write_reg, mem_mem_to_reg, mem_halt, halt_seen
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset (used under EX_MEM_PERF_EN).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, sticking at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall/flush, sticky halt squash and store-data forwarding.
// Optional performance counters are enabled by defining EX_MEM_PERF_EN.
module ex_mem_pipe
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_mem_pipe_if.slave bus
`ifdef EX_MEM_PERF_EN
    ,
    output logic [15:0] perf_mem_ops,
    output logic [15:0] perf_stall_cycles
`endif
);

    ctrl_t         ctrl_r;
    ctrl_t         ld_ctrl_s;
    ctrl_t         nxt_ctrl_s;
    logic [DW-1:0] alu_r;
    logic [DW-1:0] wd_r;
    logic [DW-1:0] nxt_alu_s;
    logic [DW-1:0] nxt_wd_s;
    logic          halt_seen_r;
    logic          nxt_halt_seen_s;
    logic          load_s;

    // Next-state selection: flush beats stall beats load; squashed or invalid loads become bubbles.
    always_comb begin
        load_s                = ~bus.flush & ~bus.stall & bus.ex_valid & ~halt_seen_r;
        ld_ctrl_s             = BUBBLE;
        ld_ctrl_s.valid       = 1'b1;
        ld_ctrl_s.mem_read    = bus.ex_mem_read & ~bus.ex_mem_write;
        ld_ctrl_s.mem_write   = bus.ex_mem_write;
        ld_ctrl_s.reg_write   = bus.ex_reg_write;
        ld_ctrl_s.write_reg   = bus.ex_write_reg;
        ld_ctrl_s.mem_to_reg  = bus.ex_mem_to_reg;
        ld_ctrl_s.halt        = bus.ex_halt;
        nxt_ctrl_s            = BUBBLE;
        nxt_alu_s             = '0;
        nxt_wd_s              = '0;
        nxt_halt_seen_s       = halt_seen_r;
        if (bus.flush) begin
            nxt_ctrl_s = BUBBLE;
        end else if (bus.stall) begin
            nxt_ctrl_s = ctrl_r;
            nxt_alu_s  = alu_r;
            nxt_wd_s   = wd_r;
        end else if (load_s) begin
            nxt_ctrl_s      = ld_ctrl_s;
            nxt_alu_s       = bus.ex_alu_result;
            nxt_wd_s        = fwd_store_data(bus.ex_mem_write, bus.ex_rt, bus.ex_write_data,
                                             bus.wb_reg_write, bus.wb_write_reg, bus.wb_data);
            nxt_halt_seen_s = halt_seen_r | bus.ex_halt;
        end else begin
            nxt_ctrl_s = BUBBLE;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_r      <= BUBBLE;
            alu_r       <= '0;
            wd_r        <= '0;
            halt_seen_r <= 1'b0;
        end else begin
            ctrl_r      <= nxt_ctrl_s;
            alu_r       <= nxt_alu_s;
            wd_r        <= nxt_wd_s;
            halt_seen_r <= nxt_halt_seen_s;
        end
    end

    assign bus.mem_valid      = ctrl_r.valid;
    assign bus.mem_alu_result = alu_r;
    assign bus.mem_write_data = wd_r;
    assign bus.mem_read       = ctrl_r.mem_read;
    assign bus.mem_write      = ctrl_r.mem_write;
    assign bus.mem_reg_write  = ctrl_r.reg_write;
    assign bus.mem_write_reg  = ctrl_r.write_reg;
    assign bus.mem_mem_to_reg = ctrl_r.mem_to_reg;
    assign bus.mem_halt       = ctrl_r.halt;
    assign bus.halt_seen      = halt_seen_r;

`ifdef EX_MEM_PERF_EN
    logic mem_op_inc_s;
    logic stall_inc_s;

    assign mem_op_inc_s = load_s & (bus.ex_mem_read | bus.ex_mem_write);
    assign stall_inc_s  = bus.stall & ctrl_r.valid;

    sat_counter #(.W($bits(SAT16))) u_ops_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_op_inc_s),
        .count (perf_mem_ops)
    );

    sat_counter #(.W($bits(SAT16))) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (perf_stall_cycles)
    );
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed scoreboard bench for ex_mem_pipe (perf counters checked when EX_MEM_PERF_EN is defined).
module tb_ex_mem_pipe;
    import pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] wd;
        logic        rd;
        logic        wr;
        logic        rw;
        logic [2:0]  wreg;
        logic        m2r;
        logic        halt;
        logic        hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_mem_pipe_if bus();

`ifdef EX_MEM_PERF_EN
    logic [15:0] perf_mem_ops;
    logic [15:0] perf_stall_cycles;
    logic [15:0] exp_ops    = 16'd0;
    logic [15:0] exp_stalls = 16'd0;
`endif

    ex_mem_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef EX_MEM_PERF_EN
        ,
        .perf_mem_ops      (perf_mem_ops),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    function automatic exp_t observe();
        exp_t o;
        o.valid = bus.mem_valid;
        o.alu   = bus.mem_alu_result;
        o.wd    = bus.mem_write_data;
        o.rd    = bus.mem_read;
        o.wr    = bus.mem_write;
        o.rw    = bus.mem_reg_write;
        o.wreg  = bus.mem_write_reg;
        o.m2r   = bus.mem_mem_to_reg;
        o.halt  = bus.mem_halt;
        o.hs    = bus.halt_seen;
        return o;
    endfunction

    task automatic expect_out(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                              input logic rd, input logic wr, input logic rw, input logic [2:0] wreg,
                              input logic m2r, input logic halt, input logic hs);
        exp_t e;
        e.valid = v;  e.alu = alu; e.wd = wd; e.rd = rd; e.wr = wr;
        e.rw = rw;    e.wreg = wreg; e.m2r = m2r; e.halt = halt; e.hs = hs;
        sb_q.push_back(e);
    endtask

    task automatic expect_bubble(input logic hs);
        expect_out(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, hs);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        exp_t o;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            o = observe();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: got %h, expected %h", tag, o, e);
            end
        end
    endtask

`ifdef EX_MEM_PERF_EN
    task automatic check_perf(input string tag);
        checks++;
        assert (perf_mem_ops === exp_ops) else begin
            errors++;
            $error("FAIL %s_ops: got %h, expected %h", tag, perf_mem_ops, exp_ops);
        end
        checks++;
        assert (perf_stall_cycles === exp_stalls) else begin
            errors++;
            $error("FAIL %s_stalls: got %h, expected %h", tag, perf_stall_cycles, exp_stalls);
        end
    endtask
`endif

    task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                         input logic [2:0] rt, input logic rd, input logic wr, input logic rw,
                         input logic [2:0] wreg, input logic m2r, input logic halt);
        bus.ex_valid = v;  bus.ex_alu_result = alu; bus.ex_write_data = wd; bus.ex_rt = rt;
        bus.ex_mem_read = rd; bus.ex_mem_write = wr; bus.ex_reg_write = rw;
        bus.ex_write_reg = wreg; bus.ex_mem_to_reg = m2r; bus.ex_halt = halt;
    endtask

    task automatic wb(input logic rw, input logic [2:0] r, input logic [15:0] d);
        bus.wb_reg_write = rw; bus.wb_write_reg = r; bus.wb_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        wb(1'b0, 3'd0, 16'h0000);
        tick();
        expect_bubble(1'b0);
        check_out("reset");
`ifdef EX_MEM_PERF_EN
        check_perf("reset");
`endif
        rst = 1'b1;

        // Reset mid-operation
        drive(1'b1, 16'h0040, 16'h1234, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out(1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out("store_pre_rst");
        #2 rst = 1'b0;
        #1;
        expect_bubble(1'b0);
        check_out("async_rst");
`ifdef EX_MEM_PERF_EN
        check_perf("async_rst");
`endif
        tick();
        expect_bubble(1'b0);
        check_out("rst_hold");
        rst = 1'b1;

        // Load pipes through
        drive(1'b1, 16'h0010, 16'h7777, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        expect_out(1'b1, 16'h0010, 16'h7777, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        check_out("load");
`ifdef EX_MEM_PERF_EN
        exp_ops = 16'd1;
`endif

        // Store, stall three cycles, then flush during stall
        drive(1'b1, 16'h0022, 16'hBEEF, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out(1'b1, 16'h0022, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out("store");
        bus.stall = 1'b1;
        drive(1'b1, 16'h0099, 16'h4444, 3'd2, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out(1'b1, 16'h0022, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            check_out("stall_hold");
        end
        bus.flush = 1'b1;
        tick();
        expect_bubble(1'b0);
        check_out("flush_over_stall");
`ifdef EX_MEM_PERF_EN
        exp_ops    = 16'd2;
        exp_stalls = 16'd4;
        check_perf("stall");
`endif
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Invalid instruction becomes a bubble; stall on a bubble is not counted
        drive(1'b0, 16'h0055, 16'h5555, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        tick();
        expect_bubble(1'b0);
        check_out("invalid");
        bus.stall = 1'b1;
        tick();
        expect_bubble(1'b0);
        check_out("stall_bubble");
`ifdef EX_MEM_PERF_EN
        check_perf("invalid");
`endif
        bus.stall = 1'b0;

        // Store-data forwarding
        wb(1'b1, 3'd5, 16'hA5A5);
        drive(1'b1, 16'h0030, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out(1'b1, 16'h0030, 16'hA5A5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out("fwd_match");
        wb(1'b1, 3'd4, 16'hA5A5);
        tick();
        expect_out(1'b1, 16'h0030, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out("fwd_other_reg");
        wb(1'b0, 3'd5, 16'hA5A5);
        tick();
        expect_out(1'b1, 16'h0030, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out("fwd_no_wb");
        wb(1'b1, 3'd5, 16'hA5A5);
        drive(1'b1, 16'h0031, 16'h1111, 3'd5, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
        tick();
        expect_out(1'b1, 16'h0031, 16'h1111, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        check_out("fwd_not_store");
        wb(1'b1, 3'd0, 16'hC3C3);
        drive(1'b1, 16'h0032, 16'h2222, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out(1'b1, 16'h0032, 16'hC3C3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out("fwd_reg0");
        wb(1'b0, 3'd0, 16'h0000);
`ifdef EX_MEM_PERF_EN
        exp_ops = 16'd7;
        check_perf("fwd");
`endif

        // Read and write both set: store wins
        drive(1'b1, 16'h0040, 16'h0BAD, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out(1'b1, 16'h0040, 16'h0BAD, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out("both_rw");
`ifdef EX_MEM_PERF_EN
        exp_ops = 16'd8;
        check_perf("both_rw");
`endif

        // Halt is sticky and squashes later instructions
        drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        expect_out(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        check_out("halt");
        bus.stall = 1'b1;
        tick();
        expect_out(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        check_out("halt_stall");
        bus.stall = 1'b0;
        drive(1'b1, 16'h0100, 16'h3333, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        expect_bubble(1'b1);
        check_out("post_halt_store");
        drive(1'b1, 16'h0104, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        tick();
        expect_bubble(1'b1);
        check_out("post_halt_load");
        bus.flush = 1'b1;
        tick();
        expect_bubble(1'b1);
        check_out("post_halt_flush");
        bus.flush = 1'b0;
        bus.stall = 1'b1;
        tick();
        expect_bubble(1'b1);
        check_out("post_halt_stall");
        bus.stall = 1'b0;
`ifdef EX_MEM_PERF_EN
        exp_stalls = 16'd5;
        check_perf("halt");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
